// File: rtl/multi_host_system_bus.sv
// Round-robin multi-host bus: NUM_HOST hosts share one device port, base/mask decode, dummy response on unmapped access.
// Optional watchdog for stalled devices is built when SYSTEM_BUS_TIMEOUT_EN is defined.
module multi_host_system_bus #(
   parameter int NUM_HOST       = 2,
   parameter int NUM_DEVICE     = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_HOST*32-1:0]   host_rw_address,
   output logic [NUM_HOST*32-1:0]   host_read_data,
   input  logic [NUM_HOST-1:0]      host_read_request,
   output logic [NUM_HOST-1:0]      host_read_response,
   input  logic [NUM_HOST*32-1:0]   host_write_data,
   input  logic [NUM_HOST*4-1:0]    host_write_strobe,
   input  logic [NUM_HOST-1:0]      host_write_request,
   output logic [NUM_HOST-1:0]      host_write_response,
   output logic [31:0]              device_rw_address,
   output logic [31:0]              device_write_data,
   output logic [3:0]               device_write_strobe,
   input  logic [NUM_DEVICE*32-1:0] device_read_data,
   output logic [NUM_DEVICE-1:0]    device_read_request,
   output logic [NUM_DEVICE-1:0]    device_write_request,
   input  logic [NUM_DEVICE-1:0]    device_read_response,
   input  logic [NUM_DEVICE-1:0]    device_write_response,
   input  logic [NUM_DEVICE*32-1:0] addr_base,
   input  logic [NUM_DEVICE*32-1:0] addr_mask,
   output logic                     bus_error
);

   localparam int HW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1;
   localparam int DW = (NUM_DEVICE > 1) ? $clog2(NUM_DEVICE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NOP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [HW-1:0]   r_grant;
   logic [HW-1:0]   r_last_grant;
   logic            r_is_write;
   logic [DW-1:0]   r_dev;

   logic [HW-1:0]   w_arb_grant;
   logic            w_any_req;
   logic [HW-1:0]   w_mux_host;
   logic [DW-1:0]   w_dec_dev;
   logic            w_dec_hit;
   logic            w_issue;
   logic            w_ok_done;
   logic            w_err_done;
   logic            w_done;
   logic            w_dev_resp;
   logic [31:0]     w_rsp_data;

   logic [31:0]     w_h_addr  [NUM_HOST];
   logic [31:0]     w_h_wdata [NUM_HOST];
   logic [3:0]      w_h_strb  [NUM_HOST];
   logic [NUM_HOST-1:0] w_h_req;
   logic [31:0]     w_d_rdata [NUM_DEVICE];
   logic [31:0]     w_d_base  [NUM_DEVICE];
   logic [31:0]     w_d_mask  [NUM_DEVICE];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_HOST; gi++) begin : g_host
         assign w_h_addr[gi]  = host_rw_address[gi*32 +: 32];
         assign w_h_wdata[gi] = host_write_data[gi*32 +: 32];
         assign w_h_strb[gi]  = host_write_strobe[gi*4 +: 4];
         assign w_h_req[gi]   = host_read_request[gi] | host_write_request[gi];

         assign host_read_response[gi]  = w_done && !r_is_write && (r_grant == HW'(gi));
         assign host_write_response[gi] = w_done &&  r_is_write && (r_grant == HW'(gi));
         assign host_read_data[gi*32 +: 32] = host_read_response[gi] ? w_rsp_data : 32'h0;
      end

      for (gi = 0; gi < NUM_DEVICE; gi++) begin : g_dev
         assign w_d_rdata[gi] = device_read_data[gi*32 +: 32];
         assign w_d_base[gi]  = addr_base[gi*32 +: 32];
         assign w_d_mask[gi]  = addr_mask[gi*32 +: 32];

         assign device_read_request[gi]  = w_issue && w_dec_hit && !r_is_write && (w_dec_dev == DW'(gi));
         assign device_write_request[gi] = w_issue && w_dec_hit &&  r_is_write && (w_dec_dev == DW'(gi));
      end
   endgenerate

   // Outside IDLE the device port follows the granted host; in IDLE it shows host 0.
   assign w_mux_host          = (r_state == S_IDLE) ? '0 : r_grant;
   assign device_rw_address   = w_h_addr[w_mux_host];
   assign device_write_data   = w_h_wdata[w_mux_host];
   assign device_write_strobe = w_h_strb[w_mux_host];

   // Scan from the far end so the nearest requester after last_grant wins.
   always_comb begin
      int v_idx;
      w_any_req   = 1'b0;
      w_arb_grant = '0;
      v_idx       = 0;
      for (int k = NUM_HOST; k >= 1; k--) begin
         v_idx = (int'(r_last_grant) + k) % NUM_HOST;
         if (w_h_req[v_idx]) begin
            w_any_req   = 1'b1;
            w_arb_grant = HW'(v_idx);
         end
      end
   end

   // Descending scan leaves the lowest-index matching device selected.
   always_comb begin
      w_dec_hit = 1'b0;
      w_dec_dev = '0;
      for (int d = NUM_DEVICE - 1; d >= 0; d--) begin
         if ((device_rw_address & w_d_mask[d]) == w_d_base[d]) begin
            w_dec_hit = 1'b1;
            w_dec_dev = DW'(d);
         end
      end
   end

   assign w_dev_resp = r_is_write ? device_write_response[r_dev] : device_read_response[r_dev];
   assign w_done     = w_ok_done | w_err_done;
   assign w_rsp_data = w_ok_done ? w_d_rdata[r_dev] : 32'h0;
   assign bus_error  = w_err_done;

`ifdef SYSTEM_BUS_TIMEOUT_EN
   localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

   logic [CW-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset || r_state != S_WAIT) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_ok_done    = 1'b0;
      w_err_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_issue      = 1'b1;
            w_state_next = w_dec_hit ? S_WAIT : S_NOP;
         end
         S_WAIT: begin
            if (w_dev_resp) begin
               w_ok_done    = 1'b1;
               w_state_next = S_IDLE;
            end
`ifdef SYSTEM_BUS_TIMEOUT_EN
            else if (r_count == CW'(TIMEOUT_CYCLES)) begin
               w_err_done   = 1'b1;
               w_state_next = S_IDLE;
            end
`endif
         end
         S_NOP: begin
            w_err_done   = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= HW'(NUM_HOST - 1);
         r_is_write   <= 1'b0;
         r_dev        <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && w_any_req) begin
            r_grant    <= w_arb_grant;
            r_is_write <= host_write_request[w_arb_grant];
         end
         if (r_state == S_ISSUE) begin
            r_dev <= w_dec_dev;
         end
         if (w_done) begin
            r_last_grant <= r_grant;
         end
      end
   end

endmodule

// File: tb/tb_multi_host_system_bus.sv
// Directed bench for multi_host_system_bus with a small latency/stall device model.
module tb_multi_host_system_bus;

   localparam int NH = 2;
   localparam int ND = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [31:0] h_addr [NH];
   logic [31:0] h_wdata[NH];
   logic [3:0]  h_strb [NH];
   logic        h_rreq [NH];
   logic        h_wreq [NH];

   logic [31:0] dev_data[ND];
   logic [31:0] base    [ND];
   logic [31:0] mask    [ND];
   bit   [ND-1:0] d_rresp;
   bit   [ND-1:0] d_wresp;

   logic [NH*32-1:0] host_rw_address, host_read_data, host_write_data;
   logic [NH*4-1:0]  host_write_strobe;
   logic [NH-1:0]    host_read_request, host_read_response, host_write_request, host_write_response;
   logic [31:0]      device_rw_address, device_write_data;
   logic [3:0]       device_write_strobe;
   logic [ND*32-1:0] device_read_data, addr_base, addr_mask;
   logic [ND-1:0]    device_read_request, device_write_request;
   logic             bus_error;

   assign host_rw_address    = {h_addr[1], h_addr[0]};
   assign host_write_data    = {h_wdata[1], h_wdata[0]};
   assign host_write_strobe  = {h_strb[1], h_strb[0]};
   assign host_read_request  = {h_rreq[1], h_rreq[0]};
   assign host_write_request = {h_wreq[1], h_wreq[0]};
   assign device_read_data   = {dev_data[2], dev_data[1], dev_data[0]};
   assign addr_base          = {base[2], base[1], base[0]};
   assign addr_mask          = {mask[2], mask[1], mask[0]};

   multi_host_system_bus #(
      .NUM_HOST(NH), .NUM_DEVICE(ND), .TIMEOUT_CYCLES(4)
   ) dut (
      .clock(clock), .reset(reset),
      .host_rw_address(host_rw_address), .host_read_data(host_read_data),
      .host_read_request(host_read_request), .host_read_response(host_read_response),
      .host_write_data(host_write_data), .host_write_strobe(host_write_strobe),
      .host_write_request(host_write_request), .host_write_response(host_write_response),
      .device_rw_address(device_rw_address), .device_write_data(device_write_data),
      .device_write_strobe(device_write_strobe), .device_read_data(device_read_data),
      .device_read_request(device_read_request), .device_write_request(device_write_request),
      .device_read_response(d_rresp), .device_write_response(d_wresp),
      .addr_base(addr_base), .addr_mask(addr_mask), .bus_error(bus_error)
   );

   // Device model: responds dev_lat cycles after its request; stall holds the response; ignores bus reset.
   int dev_lat [ND];
   bit dev_stall[ND];
   bit pend_rd [ND];
   bit pend_wr [ND];
   int cnt     [ND];

   always @(posedge clock) begin
      for (int d = 0; d < ND; d++) begin
         d_rresp[d] <= 1'b0;
         d_wresp[d] <= 1'b0;
         if (device_read_request[d] || device_write_request[d]) begin
            if (dev_lat[d] == 1 && !dev_stall[d]) begin
               d_rresp[d] <= device_read_request[d];
               d_wresp[d] <= device_write_request[d];
               pend_rd[d] <= 1'b0;
               pend_wr[d] <= 1'b0;
            end else begin
               pend_rd[d] <= device_read_request[d];
               pend_wr[d] <= device_write_request[d];
               cnt[d]     <= dev_lat[d] - 1;
            end
         end else if ((pend_rd[d] || pend_wr[d]) && !dev_stall[d]) begin
            if (cnt[d] <= 1) begin
               d_rresp[d] <= pend_rd[d];
               d_wresp[d] <= pend_wr[d];
               pend_rd[d] <= 1'b0;
               pend_wr[d] <= 1'b0;
            end else begin
               cnt[d] <= cnt[d] - 1;
            end
         end
      end
   end

   // Monitor sampled on the falling edge.
   int cyc = 0;
   int n_drd[ND], n_dwr[ND], n_hrd[NH], n_hwr[NH];
   int n_err = 0;
   int resp_cyc[NH];
   logic [31:0] resp_data[NH];
   logic [31:0] log_data[$];
   logic [3:0]  log_strb[$];

   always @(negedge clock) begin
      cyc++;
      for (int d = 0; d < ND; d++) begin
         n_drd[d] += int'(device_read_request[d]);
         n_dwr[d] += int'(device_write_request[d]);
      end
      for (int h = 0; h < NH; h++) begin
         if (host_read_response[h]) begin
            n_hrd[h]++;
            resp_cyc[h]  = cyc;
            resp_data[h] = host_read_data[h*32 +: 32];
         end
         if (host_write_response[h]) begin
            n_hwr[h]++;
            resp_cyc[h] = cyc;
         end
      end
      if (bus_error) n_err++;
      if (|device_write_request) begin
         log_data.push_back(device_write_data);
         log_strb.push_back(device_write_strobe);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic start_req(input int h, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int t0);
      @(posedge clock); #1;
      h_addr[h]  = a;
      h_wdata[h] = d;
      h_strb[h]  = s;
      if (wr) h_wreq[h] = 1'b1;
      else    h_rreq[h] = 1'b1;
      t0 = cyc;
   endtask

   task automatic wait_resp(input int h, input int budget, output bit ok);
      int start;
      start = n_hrd[h] + n_hwr[h];
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clock);
         if (n_hrd[h] + n_hwr[h] != start) ok = 1'b1;
      end
      #1;
      h_rreq[h] = 1'b0;
      h_wreq[h] = 1'b0;
   endtask

   task automatic xact(input string name, input int h, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, output int lat);
      int t0;
      bit ok;
      start_req(h, wr, a, d, s, t0);
      wait_resp(h, 40, ok);
      check_eq({name, "_done"}, {31'b0, ok}, 32'd1);
      lat = resp_cyc[h] - t0;
      $display("[TB] %s host%0d %s addr=0x%08h lat=%0d rdata=0x%08h", name, h, wr ? "WR" : "RD",
               a, lat, resp_data[h]);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int lat, s_drd, s_dwr0, s_dwr2, s_hrd, s_hwr, s_err, s_dall, b0, b1;
      bit ok;
      logic [31:0] exp_d[4];
      logic [3:0]  exp_s[4];

      reset = 1'b1;
      for (int h = 0; h < NH; h++) begin
         h_rreq[h] = 1'b0; h_wreq[h] = 1'b0; h_wdata[h] = '0; h_strb[h] = '0;
      end
      h_addr[0] = 32'h0000_1234;
      h_addr[1] = 32'h0000_5555;
      base[0] = 32'h1000_0000; mask[0] = 32'hF000_0000; dev_data[0] = 32'h0000_AAAA;
      base[1] = 32'h8000_0000; mask[1] = 32'hF000_0000; dev_data[1] = 32'h1234_5678;
      base[2] = 32'h2000_0000; mask[2] = 32'hF000_0000; dev_data[2] = 32'h2222_0002;
      for (int d = 0; d < ND; d++) begin
         dev_lat[d] = 1; dev_stall[d] = 1'b0;
      end

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("rst_hrd_resp", {30'b0, host_read_response}, 32'h0);
      check_eq("rst_hwr_resp", {30'b0, host_write_response}, 32'h0);
      check_eq("rst_dev_req", {26'b0, device_read_request, device_write_request}, 32'h0);
      check_eq("rst_bus_err", {31'b0, bus_error}, 32'h0);
      check_eq("rst_rdata0", host_read_data[31:0], 32'h0);
      check_eq("rst_rdata1", host_read_data[63:32], 32'h0);
      check_eq("rst_addr_mux_h0", device_rw_address, 32'h0000_1234);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single read through device 1
      s_drd = n_drd[1]; s_err = n_err;
      xact("single_rd", 0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat);
      check_eq("single_dev1_req", 32'(n_drd[1] - s_drd), 32'd1);
      check_eq("single_lat", 32'(lat), 32'd3);
      check_eq("single_data", resp_data[0], 32'h1234_5678);
      check_eq("single_no_err", 32'(n_err - s_err), 32'd0);

      // Unmapped read from host 1
      s_dall = n_drd[0] + n_drd[1] + n_drd[2] + n_dwr[0] + n_dwr[1] + n_dwr[2];
      s_err = n_err; s_hrd = n_hrd[1];
      xact("unmapped", 1, 1'b0, 32'hDEAD_0000, 32'h0, 4'h0, lat);
      check_eq("unmap_resp", 32'(n_hrd[1] - s_hrd), 32'd1);
      check_eq("unmap_data", resp_data[1], 32'h0);
      check_eq("unmap_err", 32'(n_err - s_err), 32'd1);
      check_eq("unmap_lat", 32'(lat), 32'd3);
      check_eq("unmap_no_dev",
               32'(n_drd[0] + n_drd[1] + n_drd[2] + n_dwr[0] + n_dwr[1] + n_dwr[2] - s_dall), 32'd0);

      // Overlapping decode: devices 0 and 2 both match
      @(posedge clock); #1;
      base[2] = 32'h1000_0000; mask[2] = 32'hFF00_0000;
      s_dwr0 = n_dwr[0]; s_dwr2 = n_dwr[2]; s_hwr = n_hwr[0];
      xact("overlap", 0, 1'b1, 32'h1000_0040, 32'hCAFE_F00D, 4'hF, lat);
      check_eq("ovl_dev0", 32'(n_dwr[0] - s_dwr0), 32'd1);
      check_eq("ovl_dev2", 32'(n_dwr[2] - s_dwr2), 32'd0);
      check_eq("ovl_hresp", 32'(n_hwr[0] - s_hwr), 32'd1);
      @(posedge clock); #1;
      base[2] = 32'h2000_0000; mask[2] = 32'hF000_0000;

      // Round-robin: both hosts write continuously, two transactions each
      do_reset();
      log_data.delete(); log_strb.delete();
      b0 = n_hwr[0]; b1 = n_hwr[1];
      h_addr[0] = 32'h1000_0000; h_wdata[0] = 32'hA0A0_0001; h_strb[0] = 4'h3;
      h_addr[1] = 32'h2000_0004; h_wdata[1] = 32'hB1B1_0002; h_strb[1] = 4'hC;
      h_wreq[0] = 1'b1; h_wreq[1] = 1'b1;
      for (int i = 0; i < 60 && (h_wreq[0] || h_wreq[1]); i++) begin
         @(posedge clock); #1;
         if (n_hwr[0] - b0 >= 2) h_wreq[0] = 1'b0;
         if (n_hwr[1] - b1 >= 2) h_wreq[1] = 1'b0;
      end
      h_wreq[0] = 1'b0; h_wreq[1] = 1'b0;
      exp_d[0] = 32'hA0A0_0001; exp_s[0] = 4'h3;
      exp_d[1] = 32'hB1B1_0002; exp_s[1] = 4'hC;
      exp_d[2] = 32'hA0A0_0001; exp_s[2] = 4'h3;
      exp_d[3] = 32'hB1B1_0002; exp_s[3] = 4'hC;
      check_eq("rr_grants", 32'(log_data.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_data.size(); i++) begin
         $display("[TB] rr grant %0d data=0x%08h strobe=0x%0h", i, log_data[i], log_strb[i]);
         check_eq($sformatf("rr_data%0d", i), log_data[i], exp_d[i]);
         check_eq($sformatf("rr_strb%0d", i), {28'b0, log_strb[i]}, {28'b0, exp_s[i]});
      end
      check_eq("rr_h0_resp", 32'(n_hwr[0] - b0), 32'd2);
      check_eq("rr_h1_resp", 32'(n_hwr[1] - b1), 32'd2);

      // Reset while device 1 is stalled, then it answers late
      dev_stall[1] = 1'b1;
      s_drd = n_drd[1];
      start_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, lat);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(posedge clock);
         if (n_drd[1] != s_drd) ok = 1'b1;
      end
      check_eq("rstw_issued", {31'b0, ok}, 32'd1);
      repeat (2) @(posedge clock);
      #1;
      s_hrd = n_hrd[0]; s_err = n_err;
      reset = 1'b1;
      h_rreq[0] = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      dev_stall[1] = 1'b0;
      repeat (6) @(posedge clock);
      $display("[TB] reset_mid_wait host0 late device response dropped");
      check_eq("rstw_no_resp", 32'(n_hrd[0] - s_hrd), 32'd0);
      check_eq("rstw_no_err", 32'(n_err - s_err), 32'd0);
      xact("after_rst", 0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, lat);
      check_eq("after_rst_data", resp_data[0], 32'h1234_5678);
      check_eq("after_rst_lat", 32'(lat), 32'd3);

`ifdef SYSTEM_BUS_TIMEOUT_EN
      // Watchdog: device never answers, TIMEOUT_CYCLES=4 fires on the 5th WAIT cycle
      dev_stall[1] = 1'b1;
      s_err = n_err;
      xact("timeout", 0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, lat);
      check_eq("to_lat", 32'(lat), 32'd7);
      check_eq("to_data", resp_data[0], 32'h0);
      check_eq("to_err", 32'(n_err - s_err), 32'd1);
      @(posedge clock); #1;
      dev_stall[1] = 1'b0;
      repeat (4) @(posedge clock);
      s_hwr = n_hwr[1];
      xact("after_to", 1, 1'b1, 32'h1000_0008, 32'h0000_00FF, 4'h1, lat);
      check_eq("after_to_resp", 32'(n_hwr[1] - s_hwr), 32'd1);
      check_eq("after_to_lat", 32'(lat), 32'd3);
`endif

      repeat (2) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_host_system_bus.md
# multi_host_system_bus

Parametrised successor to the single-host SoC interconnect. It connects NUM_HOST bus hosts (CPU, DMA, debug) to NUM_DEVICE memory-mapped devices through one shared device port. Arbitration is round-robin, address decode uses per-device base/mask, and unmapped accesses complete with a dummy response. An optional watchdog terminates transactions that a device never answers. It sits between the hosts and the existing device set, replacing the single-host bus in multi-master SoC builds.

## Interface
- NUM_HOST, 2: number of hosts, 1..8
- NUM_DEVICE, 3: number of devices, 1..16
- TIMEOUT_CYCLES, 255: WAIT-state cycles before the watchdog fires; used only with the timeout feature
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- host_rw_address  in  NUM_HOST*32  per-host address, host i at [i*32+:32]
- host_read_data  out  NUM_HOST*32  per-host read data; valid only with that host's read response
- host_read_request  in  NUM_HOST  per-host read request
- host_read_response  out  NUM_HOST  per-host one-cycle read completion pulse
- host_write_data  in  NUM_HOST*32  per-host write data
- host_write_strobe  in  NUM_HOST*4  per-host byte strobes
- host_write_request  in  NUM_HOST  per-host write request
- host_write_response  out  NUM_HOST  per-host one-cycle write completion pulse
- device_rw_address, device_write_data, device_write_strobe  out  32/32/4  granted host's address, data and strobes
- device_read_data  in  NUM_DEVICE*32  per-device read data
- device_read_request, device_write_request  out  NUM_DEVICE  one-cycle request pulse to the decoded device
- device_read_response, device_write_response  in  NUM_DEVICE  per-device completion pulses
- addr_base, addr_mask  in  NUM_DEVICE*32  device i matches when (addr & mask_i) == base_i
- bus_error  out  1  one-cycle pulse on an unmapped access or a timeout

## Operation
- Host protocol:
  - The host raises a read or a write request and holds address, data, strobe and request stable until its response pulse.
  - If read and write are both raised, the bus treats it as a write.
- The state register has four states: IDLE, ISSUE, WAIT, NOP.
- IDLE:
  - If any host request is high, grant the first requesting host after last_grant (modulo NUM_HOST).
  - Latch the grant index and whether the access is a read or a write, then go to ISSUE.
  - If no host is requesting, stay in IDLE.
- ISSUE:
  - Decode the granted address. The lowest-index matching device wins.
  - On a match, pulse that device's read or write request for exactly one cycle, latch the device index, and go to WAIT.
  - With no match, go to NOP.
- WAIT:
  - When the latched device's matching response is high, forward it combinationally in the same cycle as a one-cycle pulse on the granted host's response.
  - On a read, also forward that device's read data.
  - Then set last_grant to the granted index and go to IDLE.
  - The response of the non-matching type is ignored.
- NOP:
  - Pulse the granted host's response with read data 0 and pulse bus_error.
  - Update last_grant and go to IDLE.
- The device_rw_address, device_write_data and device_write_strobe outputs mux the granted host's signals in every state except IDLE, where they mux host 0.
- Ungranted hosts' responses stay 0 and their read data is 0.

## Timing
- Reset forces:
  - state to IDLE;
  - last_grant to NUM_HOST-1, so host 0 has first priority;
  - all request, response and bus_error outputs to 0, and host_read_data to 0.
- Reset asserted mid-transaction abandons the transaction with no response. A late device response after reset is ignored.
- Minimum latency from request seen in IDLE to host response is 3 cycles: IDLE, then ISSUE, then a WAIT cycle with a same-cycle device response.
- An unmapped access responds in the NOP cycle, 3 cycles after the request is seen.
- At most one outstanding transaction exists. The bus re-arbitrates in the IDLE cycle after each completion.
- Fairness: a host that keeps requesting waits at most NUM_HOST-1 transactions for its grant.

## Configuration
- SYSTEM_BUS_TIMEOUT_EN defined:
  - An 8..32-bit cycle counter clears on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no device response, the host gets a response pulse with read data 0, bus_error pulses, and state returns to IDLE.
  - A device response arriving in the same cycle as expiry wins, and no error is raised.
- SYSTEM_BUS_TIMEOUT_EN undefined: no counter is built, WAIT waits indefinitely, and bus_error pulses only on unmapped accesses.

## Test plan
- **Single read.** Host 0 reads 0x8000_0010; device 1 has base 0x8000_0000, mask 0xF000_0000, data 0x1234_5678, and responds 1 cycle after its request. Required: device_read_request[1] pulses exactly once, and host_read_response[0] pulses with 0x1234_5678 3 cycles after the request.
- **Round-robin.** Hosts 0 and 1 both write continuously. Required: grants alternate 0,1,0,1, and device_write_strobe and device_write_data follow the granted host.
- **Unmapped.** Host 1 reads 0xDEAD_0000 with no match. Required: host_read_response[1] pulses with data 0 and bus_error pulses; no device request is issued.
- **Overlapping decode.** Devices 0 and 2 both match the address. Required: only device 0 is requested.
- **Reset mid-WAIT.** Reset is asserted while a device is stalled, then the device responds late. Required: no host response; the next request from host 0 completes normally.
- **Timeout, with SYSTEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4.** The device never responds. Required: the host response and bus_error pulse on the 5th WAIT cycle, and the bus accepts the next request.
